// File: rtl/cast_vc_allocator.sv
// rtl/cast_vc_allocator.sv - shared multicast output-channel allocator for one cast router
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   req_i      request mask of input p at [p*CN +: CN], 0 = no request
//   release_i  one-cycle pulse from input p, frees every output it owns
//   granted_o  one-cycle grant pulse to input p
//   sel_out_o  outputs owned by input p at [p*CN +: CN], level from grant until release
//   held_o     input p currently owns outputs
//   xb_sel_o   owner of output c at [c*PN +: PN], one-hot, 0 if free
//   busy_o     output c allocated
module cast_vc_allocator #(
  parameter int PN         = 5,
  parameter int CN         = 5,
  parameter bit RESERVE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PN*CN-1:0] req_i,
  input  logic [PN-1:0]    release_i,
  output logic [PN-1:0]    granted_o,
  output logic [PN*CN-1:0] sel_out_o,
  output logic [PN-1:0]    held_o,
  output logic [CN*PN-1:0] xb_sel_o,
  output logic [CN-1:0]    busy_o
);

  localparam int PW = (PN > 1) ? $clog2(PN) : 1;

  // Allocation state: the output set owned by each input, the round-robin
  // pointer and the registered grant pulse.
  logic [CN-1:0] own_q [PN];
  logic [PW-1:0] ptr_q;
  logic [PN-1:0] granted_q;

  logic [CN-1:0] req_a [PN];
  logic [PN-1:0] held;
  logic [CN-1:0] busy;
  logic [CN-1:0] freed;
  logic [CN-1:0] avail;
  logic [CN-1:0] reserve;
  logic [PN-1:0] pending;
  logic          head_vld;
  logic [PW-1:0] head_idx;
  logic          win_vld;
  logic [PW-1:0] win_idx;

  // Position k steps after base in round-robin order, wrapping at PN.
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= PN) s = s - PN;
    return PW'(s);
  endfunction

  always_comb begin
    for (int p = 0; p < PN; p++) begin
      req_a[p] = req_i[p*CN +: CN];
    end
  end

  // Outputs being released this cycle count as free for this cycle's
  // arbitration, so a waiting requester can take them at the same edge.
  always_comb begin
    busy  = '0;
    freed = '0;
    held  = '0;
    for (int p = 0; p < PN; p++) begin
      held[p] = |own_q[p];
      busy    = busy | own_q[p];
      if (release_i[p]) freed = freed | own_q[p];
    end
    avail = ~(busy & ~freed);
    for (int p = 0; p < PN; p++) begin
      pending[p] = (|req_a[p]) & ~held[p] & ~granted_q[p];
    end
  end

  // Head of line: first pending input from the pointer. If it is blocked, it
  // reserves its whole mask so narrower requests cannot keep stealing
  // fragments of it and starve it.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    head_vld = 1'b0;
    head_idx = '0;
    for (int k = 0; k < PN; k++) begin
      idx = rr_idx(ptr_q, k);
      if (!head_vld && pending[idx]) begin
        head_vld = 1'b1;
        head_idx = idx;
      end
    end
    if (RESERVE_EN && head_vld && ((req_a[head_idx] & ~avail) != '0)) begin
      reserve = req_a[head_idx];
    end else begin
      reserve = '0;
    end
  end

  // Winner: first input in round-robin order whose whole mask is available
  // and, unless it is the head itself, does not touch the reservation.
  always_comb begin
    logic [PW-1:0] idx;
    logic          elig;
    idx     = '0;
    elig    = 1'b0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < PN; k++) begin
      idx  = rr_idx(ptr_q, k);
      elig = pending[idx]
           && ((req_a[idx] & ~avail) == '0)
           && ((idx == head_idx) || ((req_a[idx] & reserve) == '0));
      if (!win_vld && elig) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < PN; p++) begin
        own_q[p] <= '0;
      end
      ptr_q     <= '0;
      granted_q <= '0;
    end else begin
      for (int p = 0; p < PN; p++) begin
        if (release_i[p] && held[p]) own_q[p] <= '0;
      end
      granted_q <= '0;
      // The winner never holds anything, so this cannot collide with a clear.
      if (win_vld) begin
        own_q[win_idx]     <= req_a[win_idx];
        granted_q[win_idx] <= 1'b1;
        ptr_q              <= rr_idx(win_idx, 1);
      end
    end
  end

  always_comb begin
    granted_o = granted_q;
    held_o    = held;
    busy_o    = busy;
    sel_out_o = '0;
    xb_sel_o  = '0;
    for (int p = 0; p < PN; p++) begin
      sel_out_o[p*CN +: CN] = own_q[p];
      for (int c = 0; c < CN; c++) begin
        xb_sel_o[c*PN + p] = own_q[p][c];
      end
    end
  end

  // Every output has at most one owner.
  for (genvar c = 0; c < CN; c++) begin : g_owner_chk
    assert property (@(posedge clk) disable iff (rst) $onehot0(xb_sel_o[c*PN +: PN]));
  end

endmodule

// File: doc/cast_vc_allocator.md
Name: cast_vc_allocator

Overview:
- Shared allocator for the output channels of one cast router.
- Arbitrates the per-input-stage multicast requests (CN-bit output masks) from all PN input stages.
- Grants all requested outputs of a request atomically, holds the allocation until the input stage releases it on tail-flit fire, and drives the per-output crossbar select.
- Round-robin with head-of-line reservation, so wide multicast requests are starvation-free.

Parameters:
- PN, 5, number of input stages (requesters).
- CN, 5, number of output channels; equals `CN.
- RESERVE_EN, 1, 1 = blocked head requester reserves its requested outputs; 0 = plain round-robin, no reservation.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- req_i  input  PN*CN  request mask of input p at [p*CN +: CN]; 0 = no request.
- release_i  input  PN  one-cycle pulse from input p: free every output it owns.
- granted_o  output  PN  one-cycle grant pulse to input p.
- sel_out_o  output  PN*CN  outputs owned by input p; level, valid from grant until release.
- held_o  output  PN  input p currently owns outputs.
- xb_sel_o  output  CN*PN  owner of output c at [c*PN +: PN], one-hot, 0 if free.
- busy_o  output  CN  output c allocated.

Behaviour:
- Reset (rst=1 at a clk edge): granted_o, sel_out_o, held_o, xb_sel_o and busy_o all 0; RR pointer ptr=0. Reset mid-allocation drops every allocation with no release pulses required.
- State:
  - own[p] (CN bits) per input.
  - ptr ($clog2(PN) bits, wraps PN-1 -> 0).
  - Derived: busy = OR of own[p]; held[p] = |own[p]; xb_sel[c][p] = own[p][c].
- Release:
  - release_i[p] with held[p]=1 clears own[p] at the next edge.
  - release_i[p] with held[p]=0 is ignored.
  - Released outputs are visible to the same cycle's arbitration: avail = ~(busy & ~released_mask).
- Pending[p] = (req_i[p] != 0) & ~held[p] & ~granted_o[p]. Requests from holders are ignored until release.
- Head = first pending input scanning p = ptr, ptr+1, ... mod PN.
- Reserve mask = req_i[head] if RESERVE_EN, head exists and (req_i[head] & ~avail) != 0; else 0.
- Eligible[p] = pending[p] & (req_i[p] & ~avail) == 0. Also, for p != head, (req_i[p] & reserve) == 0.
- At most one grant per cycle: the winner is the first eligible input in RR order from ptr. At the next edge:
  - own[winner] <= req_i[winner];
  - granted_o[winner] pulses 1 for exactly one cycle;
  - ptr <= (winner+1) mod PN.
- No winner: ptr unchanged. A blocked head keeps priority until its outputs free.
- Latency:
  - req_i sampled at edge t -> granted_o/sel_out_o/busy_o/xb_sel_o updated after edge t (visible cycle t+1).
  - release at edge t -> output reusable by a grant after the same edge t.
- Input stages hold req_i stable until granted_o. If req_i drops to 0 before the grant, no grant is issued. If the mask changes before the grant, the value at the granting edge is used.
- req_i bits for outputs >= CN do not exist. A full-width mask (all CN bits) is legal.
- The same input releasing and requesting in one cycle: release takes effect that edge, and the new request is arbitrated from the next cycle (held=1 at sample time).
- Invariant: each output has at most one owner. Assertion: xb_sel_o column one-hot or zero.

Test Plan:
1. Unicast: reset, req_i[0]=5'b00001 at cycle 1. Required after the edge: granted_o=5'b00001 for 1 cycle, sel_out_o[0]=00001, busy_o=00001, xb_sel_o[0]=00001, ptr=1. Then release_i[0] pulse: busy_o=0 and held_o=0 next cycle.
2. Conflict: ptr=0, inputs 1 and 2 both req 5'b00010 in the same cycle. Required: input 1 granted first, input 2 not granted while busy. Release input 1 at edge k: input 2 granted at edge k (bypass), granted_o[2] high in cycle k+1.
3. Multicast reservation (RESERVE_EN=1), ptr=3:
   - Input 0 holds 5'b00010. Input 3 req 5'b00110; input 4 req 5'b00100.
   - Required: neither granted while input 0 holds.
   - After input 0 releases: input 3 is granted 00110 atomically, then input 4 is granted after input 3 releases.
   - With RESERVE_EN=0: input 4 is granted 00100 immediately.
4. Round-robin fairness: all 5 inputs req 5'b00001 continuously, each releasing 2 cycles after its grant. Required grant order: 0,1,2,3,4,0; no input granted twice before all others are served.
5. Reset mid-operation: inputs 0 and 2 hold outputs, rst=1 for one cycle. Required next cycle: all outputs 0, ptr=0; re-requests are granted normally afterwards.
6. Illegal release: release_i[3] with held_o[3]=0, while input 1 holds 00001. Required: no state change, busy_o stays 00001.
